// File: rtl/ppm_decoder.sv
// PPM frame decoder: SOF pair, four 2-bit symbols (LSB pair first), EOF.
// Emits one byte per frame with a data_valid pulse, or a frame_err pulse on abort.
module ppm_decoder #(
  parameter int unsigned SLOT_LEN = 128,
  parameter int unsigned SOF_GAP  = 79,
  parameter int unsigned TOL      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned POS_W  = $clog2(SLOT_LEN);
  localparam int unsigned SLOT_W = CNT_W - POS_W;
  localparam int unsigned SOF_W  = 15;

  localparam logic [CNT_W-1:0]  CNT_MAX        = '1;
  localparam logic [CNT_W-1:0]  RISE_MIN       = CNT_W'(SOF_W - TOL);
  localparam logic [CNT_W-1:0]  RISE_MAX       = CNT_W'(SOF_W + TOL);
  localparam logic [CNT_W-1:0]  GAP_MIN        = CNT_W'(SOF_GAP - TOL);
  localparam logic [CNT_W-1:0]  GAP_MAX        = CNT_W'(SOF_GAP + TOL);
  localparam logic [POS_W-1:0]  POS_MIN        = POS_W'(8);
  localparam logic [POS_W-1:0]  EOF_LO         = POS_W'(16);
  localparam logic [POS_W-1:0]  EOF_LAST       = POS_W'(47);
  localparam logic [POS_W-1:0]  POS_TIMEOUT    = POS_W'(SLOT_LEN - 2);
  localparam logic [POS_W-1:0]  POS_LAST       = POS_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_DATA_SLOT = SLOT_W'(4);

  typedef enum logic [2:0] {IDLE, SOF1, SOF2, DATA, EOF} state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic               fall_q, rise_q;
  logic               seen, sof_bad;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         byte_q;
  logic [POS_W-1:0]   pos;
  logic [SLOT_W-1:0]  slot;
  logic [1:0]         sym, k;
  logic               err_c;

  // cnt is the offset from t0; slot 0 is SOF, 1..4 data, 5 EOF
  assign pos  = cnt[POS_W-1:0];
  assign slot = cnt[CNT_W-1:POS_W];
  assign sym  = pos[POS_W-1 -: 2];
  assign k    = 2'(slot - 1'b1);

  // Synchronizer plus registered edge detect: fall_q lands 3 cycles after Din
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1     <= Din;
      s2     <= s1;
      s3     <= s2;
      fall_q <= s3 & ~s2;
      rise_q <= ~s3 & s2;
    end
  end

  // Frame abort conditions; timeouts fire one cycle early so frame_err lands on the limit
  always_comb begin
    err_c = 1'b0;
    case (state)
      SOF1: err_c = rise_q ? (cnt < RISE_MIN || cnt > RISE_MAX) : (cnt == RISE_MAX);
      SOF2: err_c = fall_q ? (sof_bad || cnt > GAP_MAX) : (cnt == GAP_MAX);
      DATA: err_c = fall_q ? (slot == '0 || seen || pos < POS_MIN)
                           : (slot != '0 && !seen && pos == POS_TIMEOUT);
      EOF:  err_c = fall_q ? (pos < EOF_LO || pos > EOF_LAST) : (pos == EOF_LAST);
      default: err_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_q     <= '0;
      seen       <= 1'b0;
      sof_bad    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (err_c) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt     <= '0;
            seen    <= 1'b0;
            sof_bad <= 1'b0;
            byte_q  <= '0;
            if (fall_q) begin
              cnt   <= CNT_W'(1);
              state <= SOF1;
              busy  <= 1'b1;
            end
          end
          SOF1: if (rise_q) state <= SOF2;
          // An early second fall is only reported when the gap window closes
          SOF2: if (fall_q) begin
            if (cnt < GAP_MIN) sof_bad <= 1'b1;
            else               state   <= DATA;
          end
          DATA: begin
            if (fall_q) begin
              byte_q[{k, 1'b0} +: 2] <= sym;
              seen                   <= 1'b1;
            end
            if (pos == POS_LAST) begin
              seen <= 1'b0;
              if (slot == LAST_DATA_SLOT) state <= EOF;
            end
          end
          EOF: if (fall_q) begin
            data_out   <= byte_q;
            data_valid <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppm_decoder.sv
// Directed bench for ppm_decoder: table of frame waveforms plus hand-built
// back-to-back, glitch and mid-frame reset sequences.
module tb_ppm_decoder;

  localparam int SLOT = 128;
  localparam int NV   = 15;
  localparam int FLEN = 720;

  typedef struct {
    int sof_w;
    int gap;
    int s0;
    int s1;
    int s2;
    int s3;
    int eof;
    int extra;
    int exp_dv;
    int exp_dout;
    int exp_fe;
    int exp_fe_off;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       Din;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  int dv_n, fe_n, dv_off, fe_off, dv_first, dv_val, both, busy5;
  vec_t tv[NV];
  vec_t va, vb;

  ppm_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .Din        (Din),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line level t cycles after the first SOF fall (t<0 is idle high)
  function automatic logic lvl(input vec_t v, input int t);
    int sp[4];
    int st;
    sp = '{v.s0, v.s1, v.s2, v.s3};
    if (t < 0) return 1'b1;
    if (t < v.sof_w) return 1'b0;
    if (v.gap >= 0 && t >= v.gap && t < v.gap + 15) return 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (sp[j] >= 0) begin
        st = SLOT * (j + 1) + sp[j];
        if (t >= st && t < st + 20) return 1'b0;
      end
    end
    if (v.eof >= 0) begin
      st = 5 * SLOT + v.eof;
      if (t >= st && t < st + 20) return 1'b0;
    end
    if (v.extra >= 0 && t >= v.extra && t < v.extra + 10) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    Din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Plays frame a (and frame b starting at cycle b_at when b_at >= 0); offsets are from fall detection
  task automatic play(input vec_t a, input vec_t b, input int b_at, input int len);
    dv_n = 0; fe_n = 0; dv_off = -1; fe_off = -1;
    dv_first = -1; dv_val = -1; both = 0; busy5 = -1;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      if (data_valid) begin
        dv_n++;
        dv_off = t - 3;
        dv_val = int'(data_out);
        if (dv_first < 0) dv_first = int'(data_out);
      end
      if (frame_err) begin
        fe_n++;
        fe_off = t - 3;
      end
      if (data_valid && frame_err) both = 1;
      if (t == 8) busy5 = int'(busy);
      Din = lvl(a, t) & ((b_at >= 0) ? lvl(b, t - b_at) : 1'b1);
    end
    Din = 1'b1;
  endtask

  initial begin
    //            sof gap  s0   s1   s2   s3  eof extra dv dout  fe fe_off
    tv[0]  = '{15, 79,  48,  48,  80,  80,  31, -1, 1, 'hA5, 0, -1};
    tv[1]  = '{11, 75, 112, 112, 112, 112,  16, -1, 1, 'hFF, 0, -1};
    tv[2]  = '{19, 83,  16,  16,  16,  16,  47, -1, 1, 'h00, 0, -1};
    tv[3]  = '{15, 79,   9,  35,  70,  96,  20, -1, 1, 'hE4, 0, -1};
    tv[4]  = '{15, 79, 112,  80,  48,  16,  40, -1, 1, 'h1B, 0, -1};
    tv[5]  = '{15, 70,  -1,  -1,  -1,  -1,  -1, -1, 0, 'h1B, 1, 84};
    tv[6]  = '{10, -1,  -1,  -1,  -1,  -1,  -1, -1, 0, 'h1B, 1, 11};
    tv[7]  = '{20, -1,  -1,  -1,  -1,  -1,  -1, -1, 0, 'h1B, 1, 20};
    tv[8]  = '{15, 79,  48,   5,  -1,  -1,  -1, -1, 0, 'h1B, 1, 262};
    tv[9]  = '{15, 79,  48,   8,  80,  80,  31, -1, 1, 'hA1, 0, -1};
    tv[10] = '{15, 79,  48,  48,  -1,  -1,  -1, -1, 0, 'hA1, 1, 511};
    tv[11] = '{15, 79,  48,  48,  48,  -1,  -1, 484, 0, 'hA1, 1, 485};
    tv[12] = '{15, 79,  16,  16,  16,  16,  10, -1, 0, 'hA1, 1, 651};
    tv[13] = '{15, 79, 112, 112, 112, 112,  -1, -1, 0, 'hA1, 1, 688};
    tv[14] = '{15, 79,  -1,  -1,  -1,  -1,  -1, 110, 0, 'hA1, 1, 111};

    rst = 1'b0;
    Din = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset data_out", int'(data_out), 0);
    chk("reset data_valid", int'(data_valid), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1'b1;
    idle(5);

    for (int i = 0; i < NV; i++) begin
      idle(30);
      play(tv[i], tv[i], -1, FLEN);
      chk($sformatf("v%0d dv_count", i), dv_n, tv[i].exp_dv);
      chk($sformatf("v%0d fe_count", i), fe_n, tv[i].exp_fe);
      chk($sformatf("v%0d data_out", i), int'(data_out), tv[i].exp_dout);
      chk($sformatf("v%0d busy_in_frame", i), busy5, 1);
      chk($sformatf("v%0d busy_after", i), int'(busy), 0);
      chk($sformatf("v%0d dv_fe_overlap", i), both, 0);
      if (tv[i].exp_fe != 0)
        chk($sformatf("v%0d fe_offset", i), fe_off, tv[i].exp_fe_off);
      if (tv[i].exp_dv != 0) begin
        chk($sformatf("v%0d dv_offset", i), dv_off, 5 * SLOT + tv[i].eof + 1);
        chk($sformatf("v%0d dv_value", i), dv_val, tv[i].exp_dout);
      end
    end

    // Back-to-back FF then 00: one high cycle between EOF pulse end (676) and next SOF (677)
    idle(30);
    va = '{15, 79, 112, 112, 112, 112, 16, -1, 0, 0, 0, -1};
    vb = '{15, 79,  16,  16,  16,  16, 31, -1, 0, 0, 0, -1};
    play(va, vb, 677, 677 + FLEN);
    chk("b2b dv_count", dv_n, 2);
    chk("b2b first", dv_first, 'hFF);
    chk("b2b second", dv_val, 'h00);
    chk("b2b fe_count", fe_n, 0);
    chk("b2b second_offset", dv_off, 677 + 5 * SLOT + 31 + 1);

    // Two-cycle glitch in IDLE, then a clean 8'h5A frame
    idle(30);
    va = '{2, -1, -1, -1, -1, -1, -1, -1, 0, 0, 0, -1};
    play(va, va, -1, 40);
    chk("glitch fe_count", fe_n, 1);
    chk("glitch fe_offset", fe_off, 3);
    chk("glitch dv_count", dv_n, 0);
    chk("glitch data_out", int'(data_out), 'h00);
    idle(10);
    va = '{15, 79, 80, 80, 48, 48, 31, -1, 0, 0, 0, -1};
    play(va, va, -1, FLEN);
    chk("post_glitch dv_count", dv_n, 1);
    chk("post_glitch fe_count", fe_n, 0);
    chk("post_glitch data_out", int'(data_out), 'h5A);

    // Reset during symbol 1, then frame 8'h3C
    idle(30);
    va = '{15, 79, 48, 48, 80, 80, 31, -1, 0, 0, 0, -1};
    play(va, va, -1, 2 * SLOT + 3 + 50);
    chk("abort busy_before_rst", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("abort busy_in_rst", int'(busy), 0);
    chk("abort data_out_in_rst", int'(data_out), 0);
    both = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (frame_err) both = 1;
    end
    rst = 1'b1;
    fe_n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (frame_err) fe_n++;
    end
    chk("abort fe_in_rst", both, 0);
    chk("abort fe_after_rst", fe_n, 0);
    va = '{15, 79, 16, 112, 112, 16, 31, -1, 0, 0, 0, -1};
    play(va, va, -1, FLEN);
    chk("restart dv_count", dv_n, 1);
    chk("restart fe_count", fe_n, 0);
    chk("restart data_out", int'(data_out), 'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
